// File: rtl/ld_tid_tracker_pkg.sv
// Shared configuration and types for the load transaction-ID tracker.
// Holds the default sizing (load buffer depth, dcache ID width, metadata
// width), the per-entry record, the entry lifecycle encoding and a helper
// that classifies an entry from its valid/killed bits.
package ld_tid_tracker_pkg;

  localparam int NrLoadBufEntries = 8;
  localparam int DcacheIdWidth    = 3;
  localparam int LdMetaWidth      = 8;

  typedef logic [DcacheIdWidth-1:0] id_t;

  typedef struct packed {
    logic                   valid;
    logic                   killed;
    logic [LdMetaWidth-1:0] meta;
  } ld_entry_t;

  // Entry lifecycle: FREE -> PENDING -> (KILLED) -> FREE.
  typedef enum logic [1:0] {
    ENT_FREE    = 2'd0,
    ENT_PENDING = 2'd1,
    ENT_KILLED  = 2'd2
  } entry_state_e;

  function automatic entry_state_e entry_state(input logic valid, input logic killed);
    if (!valid) return ENT_FREE;
    if (killed) return ENT_KILLED;
    return ENT_PENDING;
  endfunction

endpackage

// File: rtl/ld_tid_tracker_lzc.sv
// Trailing-zero style priority encoder: returns the index of the lowest set
// bit of vec. none is high when vec is all zeros (cnt is then 0).
// Ports:
//   vec  in  Width     candidate bits (1 = available)
//   cnt  out CntWidth  index of the lowest set bit
//   none out 1         no bit set
module ld_tid_tracker_lzc #(
  parameter int Width    = 8,
  parameter int CntWidth = 3
) (
  input  logic [Width-1:0]    vec,
  output logic [CntWidth-1:0] cnt,
  output logic                none
);

  always_comb begin
    cnt  = '0;
    none = 1'b1;
    // Scan from the top so the lowest set bit wins.
    for (int i = Width - 1; i >= 0; i--) begin
      if (vec[i]) begin
        cnt  = CntWidth'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ld_tid_tracker.sv
// Load transaction-ID tracker between the load unit and the HPDcache load
// request port. Allocates the lowest free ID per load, stores per-load
// metadata under it, returns that metadata on the (zero-latency) response,
// and drops responses of loads that were killed or flushed in flight.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   alloc_req_i/alloc_meta_i     allocation request and metadata to store
//   alloc_gnt_o/alloc_id_o       allocation accepted / ID given
//   kill_req_i/kill_id_i         kill one in-flight load
//   flush_i                      kill all in-flight loads
//   rsp_valid_i/rsp_id_i         HPDcache response
//   rsp_valid_o/rsp_id_o/rsp_meta_o  live response forwarded to load unit
//   full_o/empty_o/count_o       occupancy (registered)
//   err_o                        sticky: rsp or kill to a non-valid ID
//
// Handshake: an allocation completes in a cycle where alloc_req_i and
// alloc_gnt_o are both high; alloc_id_o is meaningful only then. Responses
// and kills have no back-pressure and are consumed in the cycle presented.
module ld_tid_tracker
  import ld_tid_tracker_pkg::*;
#(
  parameter int NrEntries = NrLoadBufEntries,
  parameter int IdWidth   = DcacheIdWidth,
  parameter int MetaWidth = LdMetaWidth
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           alloc_req_i,
  input  logic [MetaWidth-1:0]           alloc_meta_i,
  output logic                           alloc_gnt_o,
  output logic [IdWidth-1:0]             alloc_id_o,
  input  logic                           kill_req_i,
  input  logic [IdWidth-1:0]             kill_id_i,
  input  logic                           flush_i,
  input  logic                           rsp_valid_i,
  input  logic [IdWidth-1:0]             rsp_id_i,
  output logic                           rsp_valid_o,
  output logic [IdWidth-1:0]             rsp_id_o,
  output logic [MetaWidth-1:0]           rsp_meta_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(NrEntries+1)-1:0] count_o,
  output logic                           err_o
);

  localparam int CntWidth = $clog2(NrEntries + 1);
  // Storage covers the whole ID space so any incoming ID indexes safely;
  // entries at or above NrEntries are never written and stay FREE.
  localparam int Depth = 2 ** IdWidth;
  localparam logic [IdWidth:0] IdLimit = (IdWidth + 1)'(NrEntries);

  typedef struct packed {
    logic                 valid;
    logic                 killed;
    logic [MetaWidth-1:0] meta;
  } entry_t;

  entry_t              ent_q [Depth];
  entry_t              ent_d [Depth];
  logic [CntWidth-1:0] count_q, count_d;
  logic                err_q;

  logic [NrEntries-1:0] free_vec;
  logic [IdWidth-1:0]   free_id;
  logic                 free_none;

  entry_state_e rsp_state, kill_state;
  logic         rsp_release, rsp_live, kill_same, err_set;

  always_comb begin
    free_vec = '0;
    for (int i = 0; i < NrEntries; i++) free_vec[i] = ~ent_q[i].valid;
  end

  ld_tid_tracker_lzc #(
    .Width   (NrEntries),
    .CntWidth(IdWidth)
  ) u_free_enc (
    .vec (free_vec),
    .cnt (free_id),
    .none(free_none)
  );

  // Out-of-range IDs classify as FREE so they raise err_o and touch nothing.
  always_comb begin
    rsp_state  = ({1'b0, rsp_id_i} < IdLimit)
                 ? entry_state(ent_q[rsp_id_i].valid, ent_q[rsp_id_i].killed) : ENT_FREE;
    kill_state = ({1'b0, kill_id_i} < IdLimit)
                 ? entry_state(ent_q[kill_id_i].valid, ent_q[kill_id_i].killed) : ENT_FREE;
  end

  // A kill or flush in the response cycle wins: the response is dropped
  // but the entry is still released.
  assign kill_same   = kill_req_i & (kill_id_i == rsp_id_i);
  assign rsp_release = rsp_valid_i & (rsp_state != ENT_FREE);
  assign rsp_live    = rsp_release & (rsp_state == ENT_PENDING) & ~flush_i & ~kill_same;
  assign err_set     = (rsp_valid_i & (rsp_state == ENT_FREE))
                     | (kill_req_i & (kill_state == ENT_FREE));

  // free_none is redundant with full_o but keeps a grant from ever
  // pointing at an occupied entry.
  assign alloc_gnt_o = alloc_req_i & ~full_o & ~flush_i & ~free_none;
  assign alloc_id_o  = free_id;

  assign rsp_valid_o = rsp_live;
  assign rsp_id_o    = rsp_live ? rsp_id_i : '0;
  assign rsp_meta_o  = rsp_live ? ent_q[rsp_id_i].meta : '0;

  always_comb begin
    ent_d   = ent_q;
    count_d = '0;
    for (int i = 0; i < NrEntries; i++) begin
      // The allocated entry is FREE in the registered state, so it can
      // never coincide with the released one.
      if (alloc_gnt_o && (free_id == IdWidth'(i))) begin
        ent_d[i].valid  = 1'b1;
        ent_d[i].killed = 1'b0;
        ent_d[i].meta   = alloc_meta_i;
      end else if (rsp_release && (rsp_id_i == IdWidth'(i))) begin
        ent_d[i].valid  = 1'b0;
        ent_d[i].killed = 1'b0;
      end else if (ent_q[i].valid && (flush_i || (kill_req_i && (kill_id_i == IdWidth'(i))))) begin
        ent_d[i].killed = 1'b1;
      end
      count_d = count_d + CntWidth'(ent_d[i].valid);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) ent_q[i] <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      err_q   <= err_q | err_set;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CntWidth'(NrEntries));
  assign empty_o = (count_q == '0);
  assign err_o   = err_q;

endmodule

// File: tb/tb_ld_tid_tracker.sv
// Bench for ld_tid_tracker: directed table, hand-written reset/error
// sequences, then randomized traffic against a set-based reference model.
module tb_ld_tid_tracker;

  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       alloc_req, alloc_gnt, kill_req, flush, rsp_valid_in, rsp_valid_out;
  logic [7:0] alloc_meta, rsp_meta;
  logic [2:0] alloc_id, kill_id, rsp_id_in, rsp_id_out;
  logic       full, empty, err;
  logic [3:0] count;

  ld_tid_tracker dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .alloc_req_i (alloc_req),
    .alloc_meta_i(alloc_meta),
    .alloc_gnt_o (alloc_gnt),
    .alloc_id_o  (alloc_id),
    .kill_req_i  (kill_req),
    .kill_id_i   (kill_id),
    .flush_i     (flush),
    .rsp_valid_i (rsp_valid_in),
    .rsp_id_i    (rsp_id_in),
    .rsp_valid_o (rsp_valid_out),
    .rsp_id_o    (rsp_id_out),
    .rsp_meta_o  (rsp_meta),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count),
    .err_o       (err)
  );

  typedef struct {
    logic       req;
    logic [7:0] meta;
    logic       kill;
    logic [2:0] kid;
    logic       flush;
    logic       rv;
    logic [2:0] rid;
    logic       e_gnt;
    logic [2:0] e_id;
    logic       e_rv;
    logic [7:0] e_meta;
    logic [3:0] e_cnt;
    logic       e_err;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // In-flight loads are a map id -> meta; killed loads are a set of ids.
  logic [7:0] m_meta[int];
  bit         m_killed[int];
  bit         m_err;

  task automatic model_reset();
    m_meta.delete();
    m_killed.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(inout vec_t v);
    int rid = int'(v.rid);
    int kid = int'(v.kid);
    v.e_gnt  = v.req && (m_meta.num() < N) && !v.flush;
    v.e_id   = '0;
    if (v.e_gnt)
      for (int i = N - 1; i >= 0; i--) if (!m_meta.exists(i)) v.e_id = 3'(i);
    v.e_rv   = 1'b0;
    v.e_meta = '0;
    if (v.rv) begin
      if (m_meta.exists(rid)) begin
        if (!m_killed.exists(rid) && !v.flush && !(v.kill && v.kid == v.rid)) begin
          v.e_rv   = 1'b1;
          v.e_meta = m_meta[rid];
        end
      end else m_err = 1'b1;
    end
    if (v.kill) begin
      if (m_meta.exists(kid)) m_killed[kid] = 1'b1;
      else m_err = 1'b1;
    end
    if (v.flush) foreach (m_meta[k]) m_killed[k] = 1'b1;
    if (v.rv && m_meta.exists(rid)) begin
      m_meta.delete(rid);
      if (m_killed.exists(rid)) m_killed.delete(rid);
    end
    if (v.e_gnt) m_meta[int'(v.e_id)] = v.meta;
    v.e_cnt = 4'(m_meta.num());
    v.e_err = m_err;
  endtask

  // ---------------- driver ----------------
  task automatic drive_idle();
    alloc_req = 0; alloc_meta = 0; kill_req = 0; kill_id = 0;
    flush = 0; rsp_valid_in = 0; rsp_id_in = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  task automatic apply(input vec_t v);
    logic [10:0] got;
    @(negedge clk);
    alloc_req = v.req; alloc_meta = v.meta; kill_req = v.kill; kill_id = v.kid;
    flush = v.flush; rsp_valid_in = v.rv; rsp_id_in = v.rid;
    #2;
    chk("alloc_gnt", alloc_gnt, v.e_gnt);
    if (v.e_gnt) chk("alloc_id", alloc_id, v.e_id);
    chk("rsp_valid", rsp_valid_out, v.e_rv);
    if (v.e_rv) exp_q.push_back({v.rid, v.e_meta});
    if (rsp_valid_out) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_unexpected_rsp: got id=%0d meta=0x%0h, expected no response", rsp_id_out, rsp_meta);
      end else begin
        got = exp_q.pop_front();
        chk("rsp_id_meta", {rsp_id_out, rsp_meta}, got);
      end
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      chk("rsp_idle_zero", {rsp_id_out, rsp_meta}, 11'h0);
    end
    @(posedge clk);
    #1;
    chk("count", count, v.e_cnt);
    chk("full", full, v.e_cnt == 4'(N));
    chk("empty", empty, v.e_cnt == 4'd0);
    chk("err", err, v.e_err);
  endtask

  function automatic vec_t mk(int req, int meta, int kill, int kid, int fl, int rv, int rid,
                              int e_gnt, int e_id, int e_rv, int e_meta, int e_cnt, int e_err);
    vec_t v;
    v.req = 1'(req); v.meta = 8'(meta); v.kill = 1'(kill); v.kid = 3'(kid);
    v.flush = 1'(fl); v.rv = 1'(rv); v.rid = 3'(rid);
    v.e_gnt = 1'(e_gnt); v.e_id = 3'(e_id); v.e_rv = 1'(e_rv); v.e_meta = 8'(e_meta);
    v.e_cnt = 4'(e_cnt); v.e_err = 1'(e_err);
    return v;
  endfunction

  // ---------------- test ----------------
  vec_t tbl[$];

  initial begin
    vec_t v;
    int   ids[$];
    rst = 1'b1;
    drive_idle();

    // Directed table:      req meta  kl kid fl rv rid | gnt id rv emeta cnt err
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 8'h10 + i, 0, 0, 0, 0, 0, 1, i, 0, 0, i + 1, 0));
    tbl.push_back(mk(1, 8'h18, 0, 0, 0, 0, 0,   0, 0, 0, 0,     8, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, 5,   0, 0, 1, 8'h15, 7, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, 2,   0, 0, 1, 8'h12, 6, 0));
    tbl.push_back(mk(1, 8'h22, 0, 0, 0, 0, 0,   1, 2, 0, 0,     7, 0));
    tbl.push_back(mk(0, 0,     1, 3, 0, 0, 0,   0, 0, 0, 0,     7, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, 3,   0, 0, 0, 0,     6, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, 2,   0, 0, 1, 8'h22, 5, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, 6,   0, 0, 1, 8'h16, 4, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, 7,   0, 0, 1, 8'h17, 3, 0));
    tbl.push_back(mk(1, 8'h50, 0, 0, 1, 0, 0,   0, 0, 0, 0,     3, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, 0,   0, 0, 0, 0,     2, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, 1,   0, 0, 0, 0,     1, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, 4,   0, 0, 0, 0,     0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 8'h30 + i, 0, 0, 0, 0, 0, 1, i, 0, 0, i + 1, 0));
    tbl.push_back(mk(1, 8'h40, 0, 0, 0, 1, 0,   0, 0, 1, 8'h30, 7, 0));
    tbl.push_back(mk(1, 8'h40, 0, 0, 0, 0, 0,   1, 0, 0, 0,     8, 0));
    tbl.push_back(mk(0, 0,     1, 1, 0, 1, 1,   0, 0, 0, 0,     7, 0));
    tbl.push_back(mk(0, 0,     1, 2, 0, 0, 0,   0, 0, 0, 0,     7, 0));
    tbl.push_back(mk(0, 0,     1, 2, 0, 0, 0,   0, 0, 0, 0,     7, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, 2,   0, 0, 0, 0,     6, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, 0,   0, 0, 1, 8'h40, 5, 0));
    tbl.push_back(mk(0, 0,     1, 1, 0, 0, 0,   0, 0, 0, 0,     5, 1));

    do_reset();
    foreach (tbl[i]) apply(tbl[i]);

    // Mid-operation reset clears entries and err; a response to a freed
    // ID then raises a sticky error.
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 1));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply(mk(1, 8'h61, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 8'h61, 0, 1));
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Randomized traffic against the reference model.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int c = 0; c < 500; c++) begin
        ids.delete();
        foreach (m_meta[k]) ids.push_back(k);
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.req   = ($urandom_range(0, 99) < 55);
        v.meta  = 8'($urandom_range(0, 255));
        v.kill  = ($urandom_range(0, 99) < 10);
        v.flush = ($urandom_range(0, 99) < 3);
        v.rv    = ($urandom_range(0, 99) < 45);
        if (ids.size() > 0 && $urandom_range(0, 19) != 0)
          v.rid = 3'(ids[$urandom_range(0, ids.size() - 1)]);
        else
          v.rid = 3'($urandom_range(0, 7));
        if (ids.size() > 0 && $urandom_range(0, 9) != 0)
          v.kid = 3'(ids[$urandom_range(0, ids.size() - 1)]);
        else
          v.kid = 3'($urandom_range(0, 7));
        model_step(v);
        apply(v);
      end
    end

    @(negedge clk);
    drive_idle();
    chk("sb_drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
